// File: rtl/wordcount_pkg.sv
// wordcount_pkg: shared types and widths for the wordcount sequencer.
// Holds the FSM encodings, datapath widths and a saturating helper.
package wordcount_pkg;

  localparam int COUNT_W        = 32;
  localparam int ACC_DATA_W     = 64;
  localparam int ACC_ADDR_W     = 32;
  localparam int DEF_ADDR_WIDTH = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR_KICK,
    ST_CLR_WAIT,
    ST_RUN,
    ST_DRAIN,
    ST_DUMP,
    ST_DONE
  } wc_state_t;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_RD_ISSUE,
    DS_RD_WAIT,
    DS_OUT_HOLD
  } dump_state_t;

  function automatic logic [COUNT_W-1:0] sat_inc(
    input logic [COUNT_W-1:0] v
  );
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/wordcount_dump_seq.sv
// wordcount_dump_seq: sweeps all buckets and streams (addr, count) out.
// Ports: start/done handshake, rd_addr/rd_data to the array, out_* stream.
module wordcount_dump_seq
  import wordcount_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter bit SKIP_ZERO  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [COUNT_W-1:0]    rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [COUNT_W-1:0]    out_count,
  output logic                  out_last
);

  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = '1;

  dump_state_t state;
  logic        at_max;
  logic        skip;

  assign at_max = (rd_addr == MAX_ADDR);
  // The final bucket is always emitted so the sink sees out_last.
  assign skip   = SKIP_ZERO && (rd_data == '0) && !at_max;
  assign done   = (state == DS_OUT_HOLD) && out_ready && out_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= DS_IDLE;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
    end else begin
      unique case (state)
        DS_IDLE: begin
          if (start) begin
            rd_addr <= '0;
            state   <= DS_RD_ISSUE;
          end
        end
        DS_RD_ISSUE: state <= DS_RD_WAIT;
        DS_RD_WAIT: begin
          out_addr  <= rd_addr;
          out_count <= rd_data;
          if (skip) begin
            rd_addr <= rd_addr + ADDR_WIDTH'(1);
            state   <= DS_RD_ISSUE;
          end else begin
            out_valid <= 1'b1;
            out_last  <= at_max;
            state     <= DS_OUT_HOLD;
          end
        end
        DS_OUT_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state <= DS_IDLE;
            end else begin
              rd_addr <= rd_addr + ADDR_WIDTH'(1);
              state   <= DS_RD_ISSUE;
            end
          end
        end
        default: state <= DS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/wordcount_ctrl.sv
// wordcount_ctrl: job sequencer (clear, accumulate, drain, dump).
// Ports: start/busy/done, in_* stream, out_* stream, acc_* array, stats.
module wordcount_ctrl
  import wordcount_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DRAIN_CYCLES = 4,
  parameter bit SKIP_ZERO    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [COUNT_W-1:0]    in_inc,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [COUNT_W-1:0]    out_count,
  output logic                  out_last,
  output logic                  acc_clear_kick,
  input  logic                  acc_clear_busy,
  output logic [ACC_ADDR_W-1:0] acc_addr,
  output logic [ACC_DATA_W-1:0] acc_din,
  output logic                  acc_we,
  input  logic [ACC_DATA_W-1:0] acc_q,
  output logic [COUNT_W-1:0]    stat_words
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 4);
  localparam logic [CNT_W-1:0] CLR_TMO = CNT_W'(3);
  localparam logic [CNT_W-1:0] DRN_END = CNT_W'(DRAIN_CYCLES - 1);

  wc_state_t             state;
  logic [CNT_W-1:0]      cnt;
  logic                  seen_busy;
  logic                  fire;
  logic                  dump_start;
  logic                  dump_done;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [31:0]           unused_q_hi;

  assign unused_q_hi = acc_q[ACC_DATA_W-1:COUNT_W];

  assign fire           = (state == ST_RUN) && in_valid;
  assign in_ready       = (state == ST_RUN);
  assign busy           = (state != ST_IDLE);
  assign done           = (state == ST_DONE);
  assign acc_clear_kick = (state == ST_CLR_KICK);
  assign acc_we         = fire;
  assign acc_din        = fire ? {{(ACC_DATA_W-COUNT_W){1'b0}}, in_inc}
                               : '0;
  assign dump_start     = (state == ST_DRAIN) && (cnt == DRN_END);

  always_comb begin
    acc_addr = '0;
    unique case (1'b1)
      fire:               acc_addr = ACC_ADDR_W'(in_addr);
      (state == ST_DUMP): acc_addr = ACC_ADDR_W'(rd_addr);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      seen_busy  <= 1'b0;
      stat_words <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            stat_words <= '0;
            state      <= ST_CLR_KICK;
          end
        end
        ST_CLR_KICK: begin
          cnt       <= '0;
          seen_busy <= 1'b0;
          state     <= ST_CLR_WAIT;
        end
        ST_CLR_WAIT: begin
          if (cnt != '1) cnt <= cnt + CNT_W'(1);
          if (acc_clear_busy) seen_busy <= 1'b1;
          // An array that never raises busy is taken as already clear.
          if (!acc_clear_busy && (seen_busy || cnt == CLR_TMO))
            state <= ST_RUN;
        end
        ST_RUN: begin
          if (fire) begin
            stat_words <= sat_inc(stat_words);
            if (in_last) begin
              cnt   <= '0;
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (dump_start) state <= ST_DUMP;
          else            cnt   <= cnt + CNT_W'(1);
        end
        ST_DUMP: if (dump_done) state <= ST_DONE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  wordcount_dump_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .SKIP_ZERO  (SKIP_ZERO)
  ) u_dump (
    .clk       (clk),
    .reset     (reset),
    .start     (dump_start),
    .done      (dump_done),
    .rd_addr   (rd_addr),
    .rd_data   (acc_q[COUNT_W-1:0]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_count (out_count),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_wordcount_ctrl.sv
// tb_wordcount_ctrl: directed table-driven bench for wordcount_ctrl.
// Two instances (AW=4 skip-zero, AW=3 no-skip) with a small array model.
module tb_wordcount_ctrl;

  typedef struct {
    int          job;
    logic [3:0]  addr;
    logic [31:0] val;
    logic        last;
  } vec_t;

  vec_t in_tab[$];
  vec_t exp_tab[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, start_b = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [3:0]  in_addr = '0;
  logic [31:0] in_inc = '0;

  logic        a_busy, a_done, a_in_ready, a_out_valid, a_out_last;
  logic [3:0]  a_out_addr;
  logic [31:0] a_out_count, a_stat;
  logic        b_busy, b_done, b_in_ready, b_out_valid, b_out_last;
  logic [2:0]  b_out_addr;
  logic [31:0] b_out_count, b_stat;

  logic        kick  [2];
  logic        cbusy [2];
  logic [31:0] aaddr [2];
  logic [63:0] adin  [2];
  logic        awe   [2];
  logic [63:0] aq    [2];

  wordcount_ctrl #(.ADDR_WIDTH(4), .DRAIN_CYCLES(4), .SKIP_ZERO(1'b1))
  dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .busy(a_busy), .done(a_done),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_addr(in_addr), .in_inc(in_inc), .in_last(in_last),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_addr(a_out_addr), .out_count(a_out_count),
    .out_last(a_out_last),
    .acc_clear_kick(kick[0]), .acc_clear_busy(cbusy[0]),
    .acc_addr(aaddr[0]), .acc_din(adin[0]), .acc_we(awe[0]),
    .acc_q(aq[0]), .stat_words(a_stat)
  );

  wordcount_ctrl #(.ADDR_WIDTH(3), .DRAIN_CYCLES(4), .SKIP_ZERO(1'b0))
  dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .busy(b_busy), .done(b_done),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_addr(in_addr[2:0]), .in_inc(in_inc), .in_last(in_last),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_addr(b_out_addr), .out_count(b_out_count),
    .out_last(b_out_last),
    .acc_clear_kick(kick[1]), .acc_clear_busy(cbusy[1]),
    .acc_addr(aaddr[1]), .acc_din(adin[1]), .acc_we(awe[1]),
    .acc_q(aq[1]), .stat_words(b_stat)
  );

  // Array model: 3-cycle we-to-write, 1-cycle read, 3-cycle clear busy.
  logic [63:0] mem [2][16] = '{default: 64'hDEAD};
  int          bcnt [2] = '{0, 0};
  logic        pw [2][3] = '{default: 1'b0};
  logic [3:0]  pa [2][3];
  logic [31:0] pd [2][3];
  int          kicks [2] = '{0, 0};
  int          dones [2] = '{0, 0};

  assign cbusy[0] = (bcnt[0] != 0);
  assign cbusy[1] = (bcnt[1] != 0);

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      aq[k] <= mem[k][aaddr[k][3:0]];
      if (pw[k][2])
        mem[k][pa[k][2]] <= mem[k][pa[k][2]] + {32'h0, pd[k][2]};
      pw[k][2] <= pw[k][1];
      pa[k][2] <= pa[k][1];
      pd[k][2] <= pd[k][1];
      pw[k][1] <= pw[k][0];
      pa[k][1] <= pa[k][0];
      pd[k][1] <= pd[k][0];
      pw[k][0] <= awe[k];
      pa[k][0] <= aaddr[k][3:0];
      pd[k][0] <= adin[k][31:0];
      if (kick[k]) begin
        bcnt[k] <= 3;
        for (int m = 0; m < 16; m++) mem[k][m] <= '0;
      end else if (bcnt[k] > 0) begin
        bcnt[k] <= bcnt[k] - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (kick[0]) kicks[0]++;
    if (kick[1]) kicks[1]++;
    if (a_done)  dones[0]++;
    if (b_done)  dones[1]++;
  end

  int          sel = 0;
  logic        cur_valid, cur_last, cur_done, cur_rdy, cur_busy;
  logic [3:0]  cur_addr;
  logic [31:0] cur_count, cur_stat;

  assign cur_valid = (sel != 0) ? b_out_valid : a_out_valid;
  assign cur_last  = (sel != 0) ? b_out_last  : a_out_last;
  assign cur_done  = (sel != 0) ? b_done      : a_done;
  assign cur_rdy   = (sel != 0) ? b_in_ready  : a_in_ready;
  assign cur_busy  = (sel != 0) ? b_busy      : a_busy;
  assign cur_addr  = (sel != 0) ? {1'b0, b_out_addr} : a_out_addr;
  assign cur_count = (sel != 0) ? b_out_count : a_out_count;
  assign cur_stat  = (sel != 0) ? b_stat      : a_stat;

  function automatic vec_t mk(int j, int a, int v, bit l);
    vec_t r;
    r.job  = j;
    r.addr = 4'(a);
    r.val  = 32'(v);
    r.last = l;
    return r;
  endfunction

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic kick_start(input int s);
    sel = s;
    @(negedge clk);
    if (s == 0) start_a = 1'b1;
    else        start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic feed(input int j, input bit poke);
    int t;
    foreach (in_tab[i]) begin
      if (in_tab[i].job == j) begin
        in_valid = 1'b1;
        in_addr  = in_tab[i].addr;
        in_inc   = in_tab[i].val;
        in_last  = in_tab[i].last;
        if (poke) start_a = 1'b1;
        t = 0;
        while (!cur_rdy && t < 50) begin
          @(negedge clk);
          t++;
        end
        if (t >= 50) check("in_ready timeout", 64'(t), 64'(0));
        @(negedge clk);
        start_a = 1'b0;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_job(input int s, input int j,
                         input int stall, input bit poke);
    vec_t got[$];
    vec_t b;
    int   k0, d0, t, ne, nin;
    k0 = kicks[s];
    d0 = dones[s];
    kick_start(s);
    feed(j, poke);
    out_ready = (stall == 0);
    t = 0;
    while (!cur_done && t < 400) begin
      if (cur_valid) begin
        b = mk(j, int'(cur_addr), int'(cur_count), cur_last);
        for (int c = 0; c < stall; c++) begin
          @(negedge clk);
          check($sformatf("j%0d stall hold c%0d", j, c),
                {cur_valid, cur_addr, cur_count, cur_last},
                {1'b1, b.addr, b.val, b.last});
        end
        stall = 0;
        out_ready = 1'b1;
        got.push_back(b);
      end
      @(negedge clk);
      t++;
    end
    check($sformatf("j%0d done seen", j), 64'(cur_done), 64'(1));
    check($sformatf("j%0d stat during done", j), 64'(cur_stat),
          64'(0) + 64'(count_in(j)));
    if (poke) start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    ne = 0;
    foreach (exp_tab[i]) begin
      if (exp_tab[i].job == j) begin
        if (ne < got.size())
          check($sformatf("j%0d beat%0d", j, ne),
                {got[ne].addr, got[ne].val, got[ne].last},
                {exp_tab[i].addr, exp_tab[i].val, exp_tab[i].last});
        ne++;
      end
    end
    nin = count_in(j);
    check($sformatf("j%0d beat count", j), 64'(got.size()), 64'(ne));
    check($sformatf("j%0d clear kicks", j), 64'(kicks[s] - k0), 64'(1));
    check($sformatf("j%0d done pulses", j), 64'(dones[s] - d0), 64'(1));
    check($sformatf("j%0d idle after", j), 64'(cur_busy), 64'(0));
    check($sformatf("j%0d stat held", j), 64'(cur_stat), 64'(nin));
  endtask

  function automatic int count_in(int j);
    int n = 0;
    foreach (in_tab[i]) if (in_tab[i].job == j) n++;
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // job 1: basic skip-zero dump
    in_tab.push_back(mk(1, 3, 1, 0));
    in_tab.push_back(mk(1, 3, 2, 0));
    in_tab.push_back(mk(1, 7, 5, 1));
    exp_tab.push_back(mk(1, 3, 3, 0));
    exp_tab.push_back(mk(1, 7, 5, 0));
    exp_tab.push_back(mk(1, 15, 0, 1));
    // job 2: back-to-back beats to one bucket, no carry-over
    for (int i = 0; i < 5; i++) in_tab.push_back(mk(2, 2, 1, i == 4));
    exp_tab.push_back(mk(2, 2, 5, 0));
    exp_tab.push_back(mk(2, 15, 0, 1));
    // job 3: no-skip instance, every bucket emitted
    in_tab.push_back(mk(3, 0, 9, 1));
    for (int i = 0; i < 8; i++)
      exp_tab.push_back(mk(3, i, (i == 0) ? 9 : 0, i == 7));
    // job 4: backpressure on the first beat
    in_tab.push_back(mk(4, 5, 4, 0));
    in_tab.push_back(mk(4, 9, 1, 1));
    exp_tab.push_back(mk(4, 5, 4, 0));
    exp_tab.push_back(mk(4, 9, 1, 0));
    exp_tab.push_back(mk(4, 15, 0, 1));
    // job 5: aborted by reset mid-dump
    in_tab.push_back(mk(5, 1, 2, 1));
    // job 6: after reset
    in_tab.push_back(mk(6, 12, 7, 1));
    exp_tab.push_back(mk(6, 12, 7, 0));
    exp_tab.push_back(mk(6, 15, 0, 1));

    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst busy/done/rdy", {a_busy, a_done, a_in_ready}, 3'b000);
    check("rst out", {a_out_valid, a_out_addr, a_out_count, a_out_last},
          '0);
    check("rst acc", {kick[0], awe[0], aaddr[0]}, '0);
    check("rst acc_din", adin[0], '0);
    check("rst stat", a_stat, '0);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("idle busy", a_busy, 0);

    run_job(0, 1, 0, 1'b0);
    run_job(0, 2, 0, 1'b1);
    run_job(1, 3, 0, 1'b0);
    run_job(0, 4, 10, 1'b0);

    kick_start(0);
    feed(5, 1'b0);
    out_ready = 1'b0;
    t = 0;
    while (!a_out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("j5 dump reached", {a_out_valid, a_out_addr, a_out_count},
          {1'b1, 4'd1, 32'd2});
    #2 reset = 1'b0;
    #1;
    check("async rst out",
          {a_out_valid, a_out_addr, a_out_count, a_out_last}, '0);
    check("async rst ctl", {a_busy, a_done, a_in_ready, kick[0], awe[0]},
          '0);
    check("async rst addr/stat", {aaddr[0], a_stat}, '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post rst idle", {a_busy, a_in_ready, a_out_valid}, '0);

    run_job(0, 6, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
